// File: rtl/mem_lsu_if.sv
// CPU request/response and word-memory bus of the load/store unit.
// The master side is the CPU plus memory; the slave side is mem_lsu.
interface mem_lsu_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_signed;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;

    logic         resp_valid;
    logic [W-1:0] resp_rdata;
    logic         resp_err;

    logic         mem_read_en;
    logic [W-1:0] mem_read_addr;
    logic [W-1:0] mem_read_data;
    logic         mem_write_en;
    logic [W-1:0] mem_write_addr;
    logic [W-1:0] mem_write_data;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_read_en, mem_read_addr,
        output mem_read_data,
        input  mem_write_en, mem_write_addr, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_read_en, mem_read_addr,
        input  mem_read_data,
        output mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit with byte/half/word access and read-modify-write
// sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses with resp_err.
module mem_lsu #(
    parameter int W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [1:0]   size_q, size_d;
    logic         sgn_q, sgn_d;
    logic         we_q, we_d;
    logic [W-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;

    logic         accept;
    logic         misaligned;
    logic         rd_en;
    logic         wr_en;
    logic [W-1:0] word_addr;
    logic [7:0]   lane_b;
    logic [15:0]  lane_h;
    logic [W-1:0] load_ext;
    logic [W-1:0] merged;

    assign accept = bus.req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            default: misaligned = (bus.req_addr[1:0] != 2'b00);
        endcase
    end
`else
    // Low address bits are simply dropped: half uses addr[1], word is aligned down.
    assign misaligned = 1'b0;
`endif

    assign rd_en     = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign wr_en     = (state_q == S_WRITE);
    assign word_addr = {addr_q[W-1:2], 2'b00};

    // Little-endian lane pick out of the fetched word.
    assign lane_b = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = bus.mem_read_data;
        case (size_q)
            SZ_BYTE: load_ext = sgn_q ? {{(W-8){lane_b[7]}}, lane_b}
                                      : {{(W-8){1'b0}}, lane_b};
            SZ_HALF: load_ext = sgn_q ? {{(W-16){lane_h[15]}}, lane_h}
                                      : {{(W-16){1'b0}}, lane_h};
            default: load_ext = bus.mem_read_data;
        endcase
    end

    always_comb begin
        merged = bus.mem_read_data;
        case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    we_d    = bus.req_we;
                    rdata_d = '0;
                    err_d   = misaligned;
                    if (misaligned)
                        state_d = S_RESP;
                    else if (!bus.req_we)
                        state_d = S_LOAD;
                    else if (bus.req_size[1])
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                // The merged word replaces the raw store data for the WRITE cycle.
                wdata_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;

    assign bus.mem_read_en    = rd_en;
    assign bus.mem_read_addr  = rd_en ? word_addr : '0;
    assign bus.mem_write_en   = wr_en;
    assign bus.mem_write_addr = wr_en ? word_addr : '0;
    assign bus.mem_write_data = wr_en ? wdata_q : '0;

    a_rw_excl: assert property (@(posedge clk) !(rd_en && wr_en));
    a_store_only_write: assert property (@(posedge clk) disable iff (rst) wr_en |-> we_q);

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter: W, default 32, word width in bits.
REQ-002 SHALL have port: clk  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  CPU access request.
REQ-005 SHALL have port: req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
REQ-006 SHALL have port: req_we  in  1  1 store, 0 load.
REQ-007 SHALL have port: req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port: req_signed  in  1  sign-extend sub-word loads.
REQ-009 SHALL have port: req_addr  in  W  byte address.
REQ-010 SHALL have port: req_wdata  in  W  store data, right-justified.
REQ-011 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  out  W  extended load data; 0 for stores.
REQ-013 SHALL have port: resp_err  out  1  misaligned access, valid with resp_valid.
REQ-014 SHALL have ports: mem_read_en out 1, mem_read_addr out W, mem_read_data in W (combinational read, same-cycle data).
REQ-015 SHALL have ports: mem_write_en out 1, mem_write_addr out W, mem_write_data out W (memory writes on clk edge).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-017 IDLE: req_ready=1; on accept, latch addr/wdata/size/signed/we.
REQ-018 From IDLE on accept: misaligned (with REQ-033) -> RESP; load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
REQ-019 All memory addresses SHALL be {addr[W-1:2],2'b00}; byte lane addr[1:0], half lane addr[1], little-endian.
REQ-020 LOAD: mem_read_en=1; extract lane, zero- or sign-extend per req_signed; register into resp_rdata; -> RESP.
REQ-021 RMW_RD: mem_read_en=1; register merged word (old word with byte/half lane replaced by req_wdata low bits); -> WRITE.
REQ-022 WRITE: mem_write_en=1 for exactly one cycle with merged or full word; -> RESP.
REQ-023 RESP: resp_valid=1 one cycle, req_ready=0; -> IDLE.
REQ-024 Latency from accept edge T: load resp at T+2, word store T+2, sub-word store T+3, misaligned T+1.
REQ-025 mem_read_en/mem_write_en SHALL never assert together; both 0 in IDLE and RESP; mem addresses/data 0 when enable low.
REQ-026 req_valid while not IDLE SHALL be ignored and not queued.
REQ-027 Misaligned access SHALL issue no memory read or write.
REQ-028 Word load with req_signed=1 SHALL return the word unchanged.

Reset
REQ-029 rst at an edge SHALL force IDLE regardless of state, including mid read-modify-write.
REQ-030 After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0.
REQ-031 A store interrupted by reset before WRITE SHALL leave memory unmodified; no response SHALL be produced.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN SHALL select alignment handling.
REQ-033 Defined: half with addr[0]=1 or word with addr[1:0]!=0 -> resp_err=1, resp_rdata=0, no memory access.
REQ-034 Undefined: low address bits ignored (half uses addr[1], word uses aligned word), resp_err tied 0, normal latency.

Verification
REQ-035 Mem[0x40]=0x8899AABB; load byte signed addr 0x41 -> resp_rdata=0xFFFFFFAA at T+2, resp_err=0.
REQ-036 Same word; load half unsigned addr 0x42 -> resp_rdata=0x00008899 at T+2.
REQ-037 Store byte 0x5C to 0x43 -> one RMW_RD read, one write of 0x5C99AABB to 0x40, resp_valid at T+3.
REQ-038 With LSU_MISALIGN_TRAP_EN, store word to 0x46 -> resp_err=1 at T+1, mem_write_en never asserted; without macro, write to 0x44.
REQ-039 Reset asserted in RMW_RD of half store 0xBEEF to 0x40 -> no write, no resp_valid, req_ready=1 next cycle, Mem[0x40] unchanged.
REQ-040 Back-to-back req_valid held high: second request accepted only in IDLE cycle after RESP; no request lost or duplicated.
